// File: rtl/dma_mem_arb_pkg.sv
// Shared DMA definitions: default geometry, arbiter state encoding and an index-width helper.
package dma_mem_arb_pkg;

    localparam int DMA_NREQ = 4;
    localparam int DMA_AW   = 21;
    localparam int DMA_DW   = 8;
    localparam int GID_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    // Width needed to index n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_mem_arb_if.sv
// Requester-side and memory-port signals of the DMA arbiter, grouped into one bundle.
interface dma_mem_arb_if
    import dma_mem_arb_pkg::*;
#(
    parameter int NREQ = DMA_NREQ,
    parameter int AW   = DMA_AW,
    parameter int DW   = DMA_DW
) ();

    logic [NREQ-1:0]    rq_req;
    logic [NREQ*AW-1:0] rq_addr;
    logic [NREQ-1:0]    rq_rnw;
    logic [NREQ*DW-1:0] rq_wd;
    logic [NREQ-1:0]    rq_ack;
    logic [NREQ-1:0]    rq_done;
    logic [DW-1:0]      rq_rd;

    logic               mem_req;
    logic [AW-1:0]      mem_addr;
    logic               mem_rnw;
    logic [DW-1:0]      mem_wd;
    logic               mem_ack;
    logic               mem_done;
    logic [DW-1:0]      mem_rd;

    // Arbiter view: takes requests, drives the memory port.
    modport slave (
        input  rq_req, rq_addr, rq_rnw, rq_wd, mem_ack, mem_done, mem_rd,
        output rq_ack, rq_done, rq_rd, mem_req, mem_addr, mem_rnw, mem_wd
    );

    // Environment view: requesters plus the memory model.
    modport master (
        output rq_req, rq_addr, rq_rnw, rq_wd, mem_ack, mem_done, mem_rd,
        input  rq_ack, rq_done, rq_rd, mem_req, mem_addr, mem_rnw, mem_wd
    );

endinterface

// File: rtl/dma_mem_arb_rr_pick.sv
// Round-robin winner selection: scans from ptr+1 upward, wrapping modulo NREQ.
module rr_pick
    import dma_mem_arb_pkg::*;
#(
    parameter int NREQ = DMA_NREQ
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] ptr,
    output logic [GID_W-1:0] win,
    output logic             valid
);

    localparam int IW = idx_w(NREQ);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the closest requester after ptr wins last.
    always_comb begin
        win   = ptr;
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                win   = GID_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_mem_arb.sv
// Round-robin arbiter that funnels NREQ DMA requesters onto one memory port, one access at a time.
module dma_mem_arb
    import dma_mem_arb_pkg::*;
#(
    parameter int NREQ = DMA_NREQ,
    parameter int AW   = DMA_AW,
    parameter int DW   = DMA_DW
) (
    input  logic             clk,
    input  logic             rst,
    dma_mem_arb_if.slave     bus,
    output logic [GID_W-1:0] grant_id,
    output logic             busy
);

    localparam int IW = idx_w(NREQ);

    arb_state_e       state_q, state_d;
    logic [GID_W-1:0] ptr_q, ptr_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             rnw_q, rnw_d;
    logic [DW-1:0]    wd_q, wd_d;

    logic [AW-1:0]    addr_arr [NREQ];
    logic [DW-1:0]    wd_arr   [NREQ];
    logic [GID_W-1:0] pick_win;
    logic             pick_valid;
    logic [IW-1:0]    pick_sel;
    logic             take, ack_hit, done_hit;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]    = bus.rq_addr[gi*AW +: AW];
            assign wd_arr[gi]      = bus.rq_wd[gi*DW +: DW];
            assign bus.rq_ack[gi]  = ack_hit  && (grant_q == GID_W'(gi));
            assign bus.rq_done[gi] = done_hit && (grant_q == GID_W'(gi));
        end
    endgenerate

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.rq_req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign pick_sel = pick_win[IW-1:0];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        wd_d     = wd_q;
        take     = 1'b0;
        ack_hit  = 1'b0;
        done_hit = 1'b0;
        case (state_q)
            ST_IDLE: take = pick_valid;
            ST_REQ: begin
                if (bus.mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion re-arbitrates immediately so back-to-back grants skip IDLE.
                if (bus.mem_done) begin
                    done_hit = 1'b1;
                    take     = pick_valid;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            state_d = ST_REQ;
            ptr_d   = pick_win;
            grant_d = pick_win;
            addr_d  = addr_arr[pick_sel];
            rnw_d   = bus.rq_rnw[pick_sel];
            wd_d    = wd_arr[pick_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= GID_W'(NREQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            rnw_q   <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.mem_req  = (state_q == ST_REQ);
    assign bus.mem_addr = addr_q;
    assign bus.mem_rnw  = rnw_q;
    assign bus.mem_wd   = wd_q;
    assign bus.rq_rd    = bus.mem_rd;
    assign grant_id     = grant_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_mem_arb.sv
// Scenario bench for dma_mem_arb: directed cases plus randomized traffic against a round-robin model.
module tb_dma_mem_arb;
    import dma_mem_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 21;
    localparam int DW   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] grant_id;
    logic       busy;

    dma_mem_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    dma_mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester-side field values as the bench intends them.
    logic [AW-1:0] fa [NREQ];
    logic          fr [NREQ];
    logic [DW-1:0] fw [NREQ];

    // Pulse monitor, sampled on the falling edge.
    int            ack_cnt  [NREQ] = '{default: 0};
    int            done_cnt [NREQ] = '{default: 0};
    int            multi_cnt = 0;
    logic [DW-1:0] done_rd = '0;

    always @(negedge clk) begin
        if ($countones(bus.rq_ack) > 1 || $countones(bus.rq_done) > 1)
            multi_cnt <= multi_cnt + 1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.rq_ack[i] === 1'b1) ack_cnt[i] <= ack_cnt[i] + 1;
            if (bus.rq_done[i] === 1'b1) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_rd     <= bus.rq_rd;
            end
        end
    end

    function automatic int sum_ack();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += ack_cnt[i];
        return s;
    endfunction

    function automatic int sum_done();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += done_cnt[i];
        return s;
    endfunction

    // Round-robin rule: first requester found after the last winner, wrapping.
    function automatic int rr_next(input int last, input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_field(input int i, input logic [AW-1:0] a, input logic r, input logic [DW-1:0] w);
        fa[i] = a; fr[i] = r; fw[i] = w;
        bus.rq_addr[i*AW +: AW] = a;
        bus.rq_rnw[i]           = r;
        bus.rq_wd[i*DW +: DW]   = w;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.rq_req   = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_rd   = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Memory-side responder for one access; reports what the port presented.
    task automatic serve(input int ack_lat, input int done_lat, input logic [DW-1:0] rd,
                         input logic [NREQ-1:0] clr_mask, input logic [NREQ-1:0] set_mask,
                         output bit tmo, output logic [2:0] gid, output logic [AW-1:0] a,
                         output logic rnw, output logic [DW-1:0] wd, output bit stable);
        int n = 0;
        tmo = 0; stable = 1; gid = '0; a = '0; rnw = 1'b0; wd = '0;
        while (bus.mem_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus.mem_req !== 1'b1) begin
            tmo = 1;
            return;
        end
        gid = grant_id; a = bus.mem_addr; rnw = bus.mem_rnw; wd = bus.mem_wd;
        for (int i = 0; i < ack_lat; i++) begin
            tick();
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== a || bus.mem_rnw !== rnw ||
                bus.mem_wd !== wd || grant_id !== gid) stable = 0;
        end
        bus.mem_ack = 1'b1;
        bus.mem_rd  = DW'($urandom);
        tick();
        bus.mem_ack = 1'b0;
        bus.rq_req  = (bus.rq_req & ~clr_mask) | set_mask;
        for (int i = 1; i < done_lat; i++) tick();
        bus.mem_done = 1'b1;
        bus.mem_rd   = rd;
        tick();
        bus.mem_done = 1'b0;
        $display("txn gid=%0d addr=%05h rnw=%0d wd=%02h rd=%02h", gid, a, rnw, wd, rd);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
        total++; if (bus.mem_rnw !== 1'b1) begin bad++; $display("FAIL reset_mem_rnw got=%0b exp=1", bus.mem_rnw); end
        set_field(2, 21'h15555, 1'b0, 8'hA7);
        bus.rq_req = 4'b0100;
        tick(); tick();
        total++; if (bus.mem_addr !== 21'h15555) begin bad++; $display("FAIL pre_rst_addr got=%0h exp=15555", bus.mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%0b exp=0", busy); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL async_mem_req got=%0b exp=0", bus.mem_req); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL async_grant got=%0d exp=0", grant_id); end
        total++; if (bus.mem_addr !== '0) begin bad++; $display("FAIL async_addr got=%0h exp=0", bus.mem_addr); end
        total++; if (bus.mem_rnw !== 1'b1) begin bad++; $display("FAIL async_rnw got=%0b exp=1", bus.mem_rnw); end
        total++; if (bus.mem_wd !== '0) begin bad++; $display("FAIL async_wd got=%0h exp=0", bus.mem_wd); end
        total++; if (bus.rq_ack !== '0 || bus.rq_done !== '0) begin bad++; $display("FAIL async_pulses got=%0b/%0b exp=0/0", bus.rq_ack, bus.rq_done); end
        bus.rq_req = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bit tmo, stable; logic [2:0] gid; logic [AW-1:0] a; logic rnw; logic [DW-1:0] wd;
        int a0, d0;
        apply_reset();
        set_field(1, 21'h1ABCD, 1'b1, 8'h00);
        a0 = sum_ack(); d0 = sum_done();
        bus.rq_req = 4'b0010;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rd_latency0 got=%0b exp=0", bus.mem_req); end
        tick();
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rd_latency1 got=%0b exp=1", bus.mem_req); end
        serve(2, 3, 8'h5A, 4'b0010, 4'b0000, tmo, gid, a, rnw, wd, stable);
        total++; if (tmo) begin bad++; $display("FAIL rd_timeout got=1 exp=0"); end
        total++; if (a !== 21'h1ABCD) begin bad++; $display("FAIL rd_addr got=%0h exp=1abcd", a); end
        total++; if (rnw !== 1'b1) begin bad++; $display("FAIL rd_rnw got=%0b exp=1", rnw); end
        total++; if (gid !== 3'd1) begin bad++; $display("FAIL rd_gid got=%0d exp=1", gid); end
        total++; if (ack_cnt[1] - (a0 - (sum_ack() - ack_cnt[1])) !== 1 && sum_ack() - a0 !== 1) begin bad++; $display("FAIL rd_ack_count got=%0d exp=1", sum_ack() - a0); end
        total++; if (sum_done() - d0 !== 1) begin bad++; $display("FAIL rd_done_count got=%0d exp=1", sum_done() - d0); end
        total++; if (done_cnt[1] !== 1) begin bad++; $display("FAIL rd_done_owner got=%0d exp=1", done_cnt[1]); end
        total++; if (done_rd !== 8'h5A) begin bad++; $display("FAIL rd_data got=%0h exp=5a", done_rd); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_contention();
        bit tmo, stable; logic [2:0] gid; logic [AW-1:0] a; logic rnw; logic [DW-1:0] wd;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_field(i, AW'(21'h10000 + i * 21'h111), 1'b1, DW'(i));
        bus.rq_req = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            serve(1, 1, DW'(t), 4'b0000, 4'b0000, tmo, gid, a, rnw, wd, stable);
            total++; if (tmo || gid !== 3'(exp_order[t])) begin bad++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", t, gid, exp_order[t]); end
            total++; if (a !== fa[exp_order[t]]) begin bad++; $display("FAIL cont_addr[%0d] got=%0h exp=%0h", t, a, fa[exp_order[t]]); end
            total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL cont_rearm[%0d] got=%0b exp=1", t, bus.mem_req); end
        end
    endtask

    task automatic test_write();
        bit tmo, stable; logic [2:0] gid; logic [AW-1:0] a; logic rnw; logic [DW-1:0] wd;
        apply_reset();
        set_field(2, 21'h0F00D, 1'b0, 8'hC3);
        bus.rq_req = 4'b0100;
        serve(5, 2, 8'h00, 4'b0100, 4'b0000, tmo, gid, a, rnw, wd, stable);
        total++; if (tmo || gid !== 3'd2) begin bad++; $display("FAIL wr_gid got=%0d exp=2", gid); end
        total++; if (wd !== 8'hC3) begin bad++; $display("FAIL wr_data got=%0h exp=c3", wd); end
        total++; if (rnw !== 1'b0) begin bad++; $display("FAIL wr_rnw got=%0b exp=0", rnw); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL wr_stable got=%0b exp=1", stable); end
    endtask

    task automatic test_withdraw();
        bit tmo, stable; logic [2:0] gid; logic [AW-1:0] a; logic rnw; logic [DW-1:0] wd;
        int d0;
        apply_reset();
        set_field(3, 21'h00333, 1'b1, 8'h00);
        d0 = done_cnt[3];
        bus.rq_req = 4'b1000;
        tick();
        tick();
        bus.rq_req = 4'b0000;
        serve(1, 2, 8'h3C, 4'b0000, 4'b0000, tmo, gid, a, rnw, wd, stable);
        total++; if (tmo || gid !== 3'd3) begin bad++; $display("FAIL wd_gid got=%0d exp=3", gid); end
        total++; if (done_cnt[3] - d0 !== 1) begin bad++; $display("FAIL wd_done got=%0d exp=1", done_cnt[3] - d0); end
        total++; if (a !== 21'h00333) begin bad++; $display("FAIL wd_addr got=%0h exp=333", a); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        bit tmo, stable; logic [2:0] gid; logic [AW-1:0] a; logic rnw; logic [DW-1:0] wd;
        int d0;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_field(i, AW'(21'h00400 + i), 1'b1, 8'h00);
        bus.rq_req = 4'b0100;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.rq_req  = '0;
        total++; if (busy !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmw_inwait got=%0b/%0b exp=1/0", busy, bus.mem_req); end
        d0 = sum_done();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        tick();
        total++; if (sum_done() !== d0) begin bad++; $display("FAIL rmw_no_done got=%0d exp=%0d", sum_done(), d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%0b exp=0", busy); end
        bus.rq_req = 4'b1001;
        serve(1, 1, 8'h11, 4'b1001, 4'b0000, tmo, gid, a, rnw, wd, stable);
        total++; if (tmo || gid !== 3'd0) begin bad++; $display("FAIL rmw_next_grant got=%0d exp=0", gid); end
    endtask

    task automatic test_spurious();
        int a0, d0;
        apply_reset();
        set_field(1, 21'h00777, 1'b1, 8'h00);
        a0 = sum_ack(); d0 = sum_done();
        bus.mem_done = 1'b1;
        #1;
        total++; if (bus.rq_done !== '0) begin bad++; $display("FAIL sp_idle_done got=%0b exp=0", bus.rq_done); end
        tick();
        bus.mem_done = 1'b0;
        bus.mem_ack  = 1'b1;
        #1;
        total++; if (bus.rq_ack !== '0) begin bad++; $display("FAIL sp_idle_ack got=%0b exp=0", bus.rq_ack); end
        tick();
        bus.mem_ack = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sp_idle_state got=%0b exp=0", busy); end
        bus.rq_req = 4'b0010;
        tick();
        bus.mem_done = 1'b1;
        #1;
        total++; if (bus.rq_done !== '0) begin bad++; $display("FAIL sp_req_done got=%0b exp=0", bus.rq_done); end
        tick();
        bus.mem_done = 1'b0;
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL sp_req_state got=%0b exp=1", bus.mem_req); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.rq_req  = '0;
        bus.mem_ack = 1'b1;
        #1;
        total++; if (bus.rq_ack !== '0) begin bad++; $display("FAIL sp_wait_ack got=%0b exp=0", bus.rq_ack); end
        tick();
        bus.mem_ack = 1'b0;
        total++; if (busy !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL sp_wait_state got=%0b/%0b exp=1/0", busy, bus.mem_req); end
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        total++; if (sum_ack() - a0 !== 1 || sum_done() - d0 !== 1) begin bad++; $display("FAIL sp_counts got=%0d/%0d exp=1/1", sum_ack() - a0, sum_done() - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sp_final_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_random();
        bit tmo, stable; logic [2:0] gid; logic [AW-1:0] a; logic rnw; logic [DW-1:0] wd;
        logic [NREQ-1:0] p, add;
        logic [DW-1:0] rd;
        int last, w, d0, m0;
        apply_reset();
        last = NREQ - 1;
        p    = '0;
        m0   = multi_cnt;
        for (int t = 0; t < 30; t++) begin
            if (p == '0) begin
                p = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++)
                    if (p[i]) set_field(i, AW'($urandom), 1'($urandom), DW'($urandom));
                bus.rq_req = p;
            end
            w   = rr_next(last, p);
            add = NREQ'($urandom) & ~p;
            for (int i = 0; i < NREQ; i++)
                if (add[i]) set_field(i, AW'($urandom), 1'($urandom), DW'($urandom));
            rd = DW'($urandom);
            d0 = done_cnt[w];
            serve($urandom_range(0, 3), $urandom_range(1, 3), rd, NREQ'(1 << w), add,
                  tmo, gid, a, rnw, wd, stable);
            total++; if (tmo || gid !== 3'(w)) begin bad++; $display("FAIL rnd_grant[%0d] got=%0d exp=%0d", t, gid, w); end
            total++; if (a !== fa[w] || rnw !== fr[w] || wd !== fw[w]) begin bad++; $display("FAIL rnd_fields[%0d] got=%0h/%0b/%0h exp=%0h/%0b/%0h", t, a, rnw, wd, fa[w], fr[w], fw[w]); end
            total++; if (stable !== 1'b1) begin bad++; $display("FAIL rnd_stable[%0d] got=0 exp=1", t); end
            total++; if (done_cnt[w] - d0 !== 1 || done_rd !== rd) begin bad++; $display("FAIL rnd_done[%0d] got=%0d/%0h exp=1/%0h", t, done_cnt[w] - d0, done_rd, rd); end
            p    = (p & ~NREQ'(1 << w)) | add;
            last = w;
        end
        total++; if (multi_cnt !== m0) begin bad++; $display("FAIL rnd_onehot got=%0d exp=%0d", multi_cnt, m0); end
    endtask

    initial begin
        bus.rq_req   = '0;
        bus.rq_addr  = '0;
        bus.rq_rnw   = '0;
        bus.rq_wd    = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_rd   = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_withdraw();
        test_reset_mid_wait();
        test_spurious();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dma_mem_arb.md
DMA_MEM_ARB -- requirements
Module: dma_mem_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of DMA requesters (2..8).
REQ-002 Parameter AW, default 21, SHALL set the DMA address width.
REQ-003 Parameter DW, default 8, SHALL set the DMA data width.
REQ-004 clk  in  1  single clock for the block.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rq_req  in  NREQ  per-requester request, held until acknowledged.
REQ-007 rq_addr  in  NREQ*AW  per-requester address, packed with requester 0 in the LSBs.
REQ-008 rq_rnw  in  NREQ  per-requester direction: 1 = read, 0 = write.
REQ-009 rq_wd  in  NREQ*DW  per-requester write data, packed.
REQ-010 rq_ack  out  NREQ  one-cycle pulse when the requester's access is accepted.
REQ-011 rq_done  out  NREQ  one-cycle pulse when the requester's access completes.
REQ-012 rq_rd  out  DW  read data broadcast to all requesters, valid with rq_done.
REQ-013 mem_req  out  1  request to the shared DMA memory port.
REQ-014 mem_addr  out  AW  address to the memory port.
REQ-015 mem_rnw  out  1  direction to the memory port.
REQ-016 mem_wd  out  DW  write data to the memory port.
REQ-017 mem_ack  in  1  memory port accepted the request.
REQ-018 mem_done  in  1  memory port completed the access.
REQ-019 mem_rd  in  DW  read data from the memory port.
REQ-020 grant_id  out  3  index of the current or last granted requester.
REQ-021 busy  out  1  high when the FSM is not in IDLE.

Function
REQ-022 FSM states SHALL be IDLE, REQ (mem_req high, waiting for mem_ack) and WAIT (waiting for mem_done).
REQ-023 Arbitration SHALL be round-robin: search starts at pointer+1 and wraps modulo NREQ; the pointer is set to the winner on grant.
REQ-024 IDLE with any rq_req high: latch the winner's addr, rnw and wd into mem_*, set grant_id, and enter REQ; mem_req is high on the next cycle (1-cycle latency).
REQ-025 In REQ, mem_req SHALL stay high and mem_* stable until mem_ack.
REQ-026 rq_ack[grant_id] SHALL equal mem_ack while in REQ (combinational, same cycle); mem_req drops on the next cycle and the FSM enters WAIT.
REQ-027 rq_done[grant_id] SHALL equal mem_done while in WAIT; rq_rd SHALL equal mem_rd combinationally at all times.
REQ-028 mem_done in WAIT with any rq_req pending: arbitrate in the same cycle and go directly to REQ (no IDLE bubble); with no request pending, go to IDLE.
REQ-029 Only one access SHALL be outstanding at a time.
REQ-030 A requester dropping rq_req while in REQ or WAIT SHALL NOT abort the access: it completes from the latched values and rq_done is still delivered.
REQ-031 mem_done in IDLE or REQ, and mem_ack in IDLE or WAIT, SHALL be ignored, with no rq_ack/rq_done pulse.
REQ-032 A requester SHALL NOT receive rq_ack and be re-granted until its previous access has completed.
REQ-033 Simultaneous requests SHALL be granted one per transaction in round-robin order; no requester waits more than NREQ-1 grants.

Reset
REQ-034 When rst is asserted, at any time including mid-transaction, the block SHALL force IDLE, mem_req=0, rq_ack=0, rq_done=0, busy=0, grant_id=0, mem_addr=0, mem_rnw=1, mem_wd=0, and pointer=NREQ-1, so requester 0 has first priority.
REQ-035 An access in flight when rst asserts SHALL be discarded; no rq_done pulse is issued for it.

Structure
REQ-036 The FSM state encoding and the default AW/DW/NREQ constants SHALL live in a shared DMA package used by dma_mem_arb and the DMA requester modules.
REQ-037 The round-robin selection SHALL be a separate combinational sub-module, rr_pick (inputs: request vector, pointer; outputs: winner index, any-valid).

Verification
REQ-038 Single read: rq_req[1]=1, rq_addr[1]=0x1ABCD, mem_ack 2 cycles after mem_req, mem_done 3 cycles later with mem_rd=0x5A -> mem_addr=0x1ABCD and mem_rnw=1; one rq_ack[1] pulse; one rq_done[1] pulse with rq_rd=0x5A.
REQ-039 Contention: all four requesters held high from reset -> grant order 0,1,2,3,0,1; mem_req reasserts on the cycle after each mem_done.
REQ-040 Write: rq_req[2]=1, rnw=0, wd=0xC3 -> mem_wd=0xC3 held stable until mem_ack, including across 5 wait cycles.
REQ-041 Withdrawal: rq_req[3] dropped the cycle after mem_req rises -> the access still completes and rq_done[3] pulses once.
REQ-042 Reset mid-WAIT: rst pulsed, then mem_done -> no rq_done pulse, busy=0, and the next grant goes to requester 0.
REQ-043 Spurious handshakes: mem_done pulsed in IDLE, and mem_ack pulsed in WAIT -> all rq_ack and rq_done stay 0 and the FSM state is unchanged.
